// File: rtl/stream_fifo_pkg.sv
// Shared types for the stream FIFO: output buffer sizing and
// the slot-demand helper used to gate RAM reads.
package stream_fifo_pkg;

  localparam int unsigned BUF_SLOTS = 2;

  typedef logic [1:0] slot_cnt_t;

  // Words that will sit in the output buffer once in-flight
  // reads land and this cycle's pop has left.
  function automatic logic [2:0] slot_demand(
    input slot_cnt_t occ,
    input logic      pending,
    input logic      pop
  );
    return {1'b0, occ} + {2'b0, pending} - {2'b0, pop};
  endfunction

endpackage

// File: rtl/stream_fifo_dual_port_memory.sv
// Simple dual-port RAM: one write port, one read port with a
// registered (1-cycle) read result.
module dual_port_memory #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             write_clock,
  input  logic             write_clock_enable,
  input  logic             write_enable,
  input  logic [AW-1:0]    write_address,
  input  logic [WIDTH-1:0] write_data,
  input  logic             read_clock,
  input  logic             read_clock_enable,
  input  logic             read_enable,
  input  logic [AW-1:0]    read_address,
  output logic [WIDTH-1:0] read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge write_clock) begin
    if (write_clock_enable && write_enable)
      mem[write_address] <= write_data;
  end

  always_ff @(posedge read_clock) begin
    if (read_clock_enable && read_enable)
      read_data <= mem[read_address];
  end

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready FIFO backed by one RAM block, with a 2-entry
// register buffer in front of the output to hide read latency.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    mem_occ;
  slot_cnt_t        buf_occ;
  slot_cnt_t        occ_next;
  logic             rd_pending;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] buf_head;
  logic [WIDTH-1:0] buf_tail;
  logic [WIDTH-1:0] head_next;
  logic [WIDTH-1:0] tail_next;
  logic             accept;
  logic             pop;
  logic             read_en;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = (buf_occ != '0);
  assign out_data  = buf_head;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Read only when the landing word is guaranteed a buffer slot.
  assign read_en = (mem_occ != '0) &&
    (slot_demand(buf_occ, rd_pending, pop) < 3'(BUF_SLOTS));

  always_comb begin
    head_next = buf_head;
    tail_next = buf_tail;
    occ_next  = buf_occ - slot_cnt_t'(pop);
    if (pop)
      head_next = buf_tail;
    if (rd_pending) begin
      if (occ_next == 2'd0)
        head_next = rd_data;
      else
        tail_next = rd_data;
      occ_next = occ_next + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_occ    <= '0;
      count      <= '0;
      buf_occ    <= '0;
      rd_pending <= 1'b0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + AW'(1);
      if (read_en)
        rd_ptr <= rd_ptr + AW'(1);
      mem_occ    <= mem_occ + CW'(accept) - CW'(read_en);
      count      <= count + CW'(accept) - CW'(pop);
      buf_occ    <= occ_next;
      rd_pending <= read_en;
    end
  end

  always_ff @(posedge clock) begin
    buf_head <= head_next;
    buf_tail <= tail_next;
  end

  dual_port_memory #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .write_clock        (clock),
    .write_clock_enable (1'b1),
    .write_enable       (accept),
    .write_address      (wr_ptr),
    .write_data         (in_data),
    .read_clock         (clock),
    .read_clock_enable  (1'b1),
    .read_enable        (read_en),
    .read_address       (rd_ptr),
    .read_data          (rd_data)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: constant vectors, corner
// sequences and random traffic against a queue-based model.
module tb_stream_fifo;

  localparam int W  = 16;
  localparam int D  = 256;
  localparam int CW = 9;

  logic          clock = 1'b0;
  logic          reset;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  stream_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int pops   = 0;
  bit armed  = 0;

  // Model: a word accepted at edge E is visible from edge E+2,
  // and order is strict queue order.
  typedef struct {
    logic [W-1:0] d;
    int           stamp;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic         iv;
    logic         rdy;
    logic [W-1:0] d;
    int           cnt;
    logic         v;
    logic [W-1:0] od;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    bit ev, acc, pp;
    ev = (q.size() > 0) && (edge_n >= q[0].stamp + 2);
    if (armed) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("in_ready", 32'(in_ready), 32'(q.size() < D));
      chk("full", 32'(full), 32'(q.size() == D));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("out_valid", 32'(out_valid), 32'(ev));
      if (ev)
        chk("out_data", 32'(out_data), 32'(q[0].d));
    end
    acc = in_valid && (q.size() < D);
    pp  = out_ready && ev;
    if (reset) begin
      q.delete();
    end else begin
      if (pp) begin
        void'(q.pop_front());
        pops++;
      end
      if (acc)
        q.push_back('{in_data, edge_n + 1});
    end
    @(posedge clock);
    edge_n++;
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'($urandom % 2);
    out_ready = 1'b1;
    in_data   = 16'hDEAD;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    armed = 1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && n < 600) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(q.size()), 0);
    out_ready = 1'b0;
  endtask

  task automatic fill_seq();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < D; i++) begin
      in_data = 16'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    bit ok;
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;

    tbl[0] = '{1'b1, 1'b0, 16'h1234, 1, 1'b0, 16'h0};
    tbl[1] = '{1'b0, 1'b1, 16'h0,    1, 1'b0, 16'h0};
    tbl[2] = '{1'b0, 1'b1, 16'h0,    1, 1'b1, 16'h1234};
    tbl[3] = '{1'b0, 1'b1, 16'h0,    0, 1'b0, 16'h0};
    tbl[4] = '{1'b1, 1'b1, 16'h00AA, 1, 1'b0, 16'h0};
    tbl[5] = '{1'b1, 1'b1, 16'h00BB, 2, 1'b0, 16'h0};
    tbl[6] = '{1'b0, 1'b0, 16'h0,    2, 1'b1, 16'h00AA};
    tbl[7] = '{1'b0, 1'b0, 16'h0,    2, 1'b1, 16'h00AA};
    tbl[8] = '{1'b0, 1'b1, 16'h0,    1, 1'b1, 16'h00BB};
    tbl[9] = '{1'b0, 1'b1, 16'h0,    0, 1'b0, 16'h0};

    repeat (2) @(posedge clock);
    #1;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].rdy;
      in_data   = tbl[i].d;
      tick();
      chk("vec_count", 32'(count), 32'(tbl[i].cnt));
      chk("vec_valid", 32'(out_valid), 32'(tbl[i].v));
      if (tbl[i].v)
        chk("vec_data", 32'(out_data), 32'(tbl[i].od));
    end

    // Fill to capacity, then offer one more word.
    fill_seq();
    chk("fill_full", 32'(full), 1);
    chk("fill_in_ready", 32'(in_ready), 0);
    chk("fill_count", 32'(count), 256);
    in_valid = 1'b1;
    in_data  = 16'h0100;
    tick();
    in_valid = 1'b0;
    chk("fill_257th", 32'(count), 256);

    // Drain from full: strict order, one word per cycle.
    out_ready = 1'b1;
    ok = 1;
    for (int i = 0; i < D; i++) begin
      if (!(out_valid && out_data == 16'(i)))
        ok = 0;
      tick();
    end
    chk("drain_order", 32'(ok), 1);
    chk("drain_empty", 32'(empty), 1);
    out_ready = 1'b0;

    // Full with simultaneous offer and pop: pop only, accept next.
    fill_seq();
    in_valid  = 1'b1;
    in_data   = 16'h0777;
    out_ready = 1'b1;
    tick();
    chk("full_pop_no_acc", 32'(count), 255);
    out_ready = 1'b0;
    tick();
    chk("full_acc_after", 32'(count), 256);
    in_valid = 1'b0;
    drain();

    // Streaming at full rate.
    pops = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in_data = 16'(i);
      tick();
    end
    chk("stream_count", 32'(count), 3);
    chk("stream_pops", 32'(pops), 997);
    drain();

    // Random traffic with pointer wrap and backpressure.
    n = 0;
    for (int cyc = 0; cyc < 60000 && n < 10000; cyc++) begin
      in_valid  = 1'($urandom % 2);
      out_ready = 1'($urandom % 2);
      in_data   = 16'($urandom);
      if (in_valid && q.size() < D)
        n++;
      tick();
    end
    chk("rand_words", 32'(n), 10000);
    drain();

    // Reset with count=37 and a read in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 38; i++) begin
      in_data = 16'h0500 + 16'(i);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("pre_rst_count", 32'(count), 37);
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0999;
    tick();
    reset     = 1'b0;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 16'hBEEF;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin
      tick();
      n++;
    end
    chk("beef_timeout", 32'(out_valid), 1);
    chk("beef_first", 32'(out_data), 32'h0000BEEF);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
